// File: rtl/ma_window_scheduler.sv
// Round-robin scheduler that shares one moving-average filter datapath between
// NUM_REQ sample channels, tracks per-channel window fill and services flushes.
module ma_window_scheduler #(
   parameter int NUM_REQ     = 2,
   parameter int WINDOW_SIZE = 4,
   parameter int DATA_W      = 6,
   parameter int CH_W        = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_flush,
   output logic                      filt_sample_valid,
   output logic [DATA_W-1:0]         filt_sample,
   output logic [CH_W-1:0]           filt_chan,
   output logic                      filt_clear,
   input  logic [DATA_W-1:0]         filt_result,
   output logic                      res_valid,
   output logic [CH_W-1:0]           res_chan,
   output logic [DATA_W-1:0]         res_data,
   input  logic                      res_ready,
   output logic [NUM_REQ-1:0]        flush_ack
);

   localparam int FILL_W = $clog2(WINDOW_SIZE + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WINDOW_SIZE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_WAIT,
      S_RESULT
   } state_t;

   state_t                    state_q;
   logic [CH_W-1:0]           ptr_q;
   logic [CH_W-1:0]           ch_q;
   logic [NUM_REQ*FILL_W-1:0] fill_q;
   logic                      filt_sample_valid_q;
   logic [DATA_W-1:0]         filt_sample_q;
   logic [CH_W-1:0]           filt_chan_q;
   logic                      filt_clear_q;
   logic                      res_valid_q;
   logic [CH_W-1:0]           res_chan_q;
   logic [DATA_W-1:0]         res_data_q;
   logic [NUM_REQ-1:0]        flush_ack_q;

   logic                      gnt_found;
   logic [CH_W-1:0]           gnt_idx;
   logic [CH_W-1:0]           fl_idx;
   logic [FILL_W-1:0]         fill_cur;

   assign fill_cur = fill_q[ch_q*FILL_W +: FILL_W];

   // Round-robin: channels above the pointer first, then wrap to the rest.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      gnt_found = 1'b0;
      gnt_idx   = '0;
      fl_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_found && req_valid[i] && (CH_W'(i) > ptr_q)) begin
            gnt_found = 1'b1;
            gnt_idx   = CH_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!gnt_found && req_valid[i] && (CH_W'(i) <= ptr_q)) begin
            gnt_found = 1'b1;
            gnt_idx   = CH_W'(i);
         end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_flush[i]) fl_idx = CH_W'(i);
      end
   end

   // Grant is combinational in IDLE only; a pending flush always wins.
   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && !rst && !(|req_flush) && gnt_found)
         req_ready = NUM_REQ'(1) << gnt_idx;
   end

   // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q             <= S_IDLE;
         ptr_q               <= CH_W'(NUM_REQ - 1);
         ch_q                <= '0;
         // NOTE: the fill counters are reset because they decide when results are released.
         fill_q              <= '0;
         filt_sample_valid_q <= 1'b0;
         filt_sample_q       <= '0;
         filt_chan_q         <= '0;
         filt_clear_q        <= 1'b0;
         res_valid_q         <= 1'b0;
         res_chan_q          <= '0;
         res_data_q          <= '0;
         flush_ack_q         <= '0;
      end else begin
         filt_sample_valid_q <= 1'b0;
         filt_clear_q        <= 1'b0;
         flush_ack_q         <= '0;
         unique case (state_q)
            S_IDLE: begin
               if (|req_flush) begin
                  ch_q         <= fl_idx;
                  filt_chan_q  <= fl_idx;
                  filt_clear_q <= 1'b1;
                  flush_ack_q  <= NUM_REQ'(1) << fl_idx;
                  state_q      <= S_CLEAR;
               end else if (gnt_found) begin
                  ch_q                <= gnt_idx;
                  ptr_q               <= gnt_idx;
                  filt_chan_q         <= gnt_idx;
                  filt_sample_q       <= req_data[gnt_idx*DATA_W +: DATA_W];
                  filt_sample_valid_q <= 1'b1;
                  state_q             <= S_ISSUE;
               end
            end
            S_CLEAR: begin
               fill_q[ch_q*FILL_W +: FILL_W] <= '0;
               filt_chan_q                   <= '0;
               state_q                       <= S_IDLE;
            end
            S_ISSUE: begin
               if (fill_cur != FILL_FULL)
                  fill_q[ch_q*FILL_W +: FILL_W] <= fill_cur + 1'b1;
               filt_sample_q <= '0;
               state_q       <= S_WAIT;
            end
            S_WAIT: begin
               filt_chan_q <= '0;
               if (fill_cur == FILL_FULL) begin
                  res_data_q  <= filt_result;
                  res_chan_q  <= ch_q;
                  res_valid_q <= 1'b1;
                  state_q     <= S_RESULT;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign filt_sample_valid = filt_sample_valid_q;
   assign filt_sample       = filt_sample_q;
   assign filt_chan         = filt_chan_q;
   assign filt_clear        = filt_clear_q;
   assign res_valid         = res_valid_q;
   assign res_chan          = res_chan_q;
   assign res_data          = res_data_q;
   assign flush_ack         = flush_ack_q;

endmodule

// File: tb/tb_ma_window_scheduler.sv
// Directed bench for ma_window_scheduler with a 4-deep moving-window filter model
// (6-bit wrapping sum) standing in for the shared filter datapath.
module tb_ma_window_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [11:0] req_data;
   logic [1:0]  req_ready;
   logic [1:0]  req_flush;
   logic        filt_sample_valid;
   logic [5:0]  filt_sample;
   logic [1:0]  filt_chan;
   logic        filt_clear;
   logic [5:0]  filt_result;
   logic        res_valid;
   logic [1:0]  res_chan;
   logic [5:0]  res_data;
   logic        res_ready;
   logic [1:0]  flush_ack;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ma_window_scheduler #(
      .NUM_REQ(2), .WINDOW_SIZE(4), .DATA_W(6), .CH_W(2)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .req_flush(req_flush),
      .filt_sample_valid(filt_sample_valid), .filt_sample(filt_sample),
      .filt_chan(filt_chan), .filt_clear(filt_clear), .filt_result(filt_result),
      .res_valid(res_valid), .res_chan(res_chan), .res_data(res_data),
      .res_ready(res_ready), .flush_ack(flush_ack)
   );

   // Filter model: result is the 6-bit sum of the newest four samples of a channel.
   logic [5:0] h0 [4];
   logic [5:0] h1 [4];
   logic [5:0] h2 [4];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            h0[i] <= '0;
            h1[i] <= '0;
            h2[i] <= '0;
         end
         filt_result <= '0;
      end else if (filt_clear) begin
         h0[filt_chan] <= '0;
         h1[filt_chan] <= '0;
         h2[filt_chan] <= '0;
      end else if (filt_sample_valid) begin
         filt_result   <= filt_sample + h0[filt_chan] + h1[filt_chan] + h2[filt_chan];
         h0[filt_chan] <= filt_sample;
         h1[filt_chan] <= h0[filt_chan];
         h2[filt_chan] <= h1[filt_chan];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one sample on channel ch (DUT must be in IDLE) and walk ISSUE and WAIT.
   task automatic send(input logic [1:0] mask, input int ch, input logic [5:0] d);
      req_valid            = mask;
      req_data[ch*6 +: 6]  = d;
      #1;
      check("grant", 32'(req_ready), 32'(1 << ch));
      step();
      check("issue_valid", 32'(filt_sample_valid), 32'd1);
      check("issue_data", 32'(filt_sample), 32'(d));
      check("issue_chan", 32'(filt_chan), 32'(ch));
      check("issue_ready", 32'(req_ready), 32'd0);
      step();
      check("wait_valid", 32'(filt_sample_valid), 32'd0);
      check("wait_chan", 32'(filt_chan), 32'(ch));
      step();
   endtask

   task automatic no_res();
      check("no_result", 32'(res_valid), 32'd0);
   endtask

   task automatic take_res(input int ch, input logic [5:0] val);
      check("res_valid", 32'(res_valid), 32'd1);
      check("res_data", 32'(res_data), 32'(val));
      check("res_chan", 32'(res_chan), 32'(ch));
      check("res_ready_gate", 32'(req_ready), 32'd0);
      step();
      check("res_done", 32'(res_valid), 32'd0);
      check("idle_chan", 32'(filt_chan), 32'd0);
   endtask

   task automatic outputs_zero(input string tag);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_fsv"}, 32'(filt_sample_valid), 32'd0);
      check({tag, "_fchan"}, 32'(filt_chan), 32'd0);
      check({tag, "_fclr"}, 32'(filt_clear), 32'd0);
      check({tag, "_rvalid"}, 32'(res_valid), 32'd0);
      check({tag, "_rdata"}, 32'(res_data), 32'd0);
      check({tag, "_rchan"}, 32'(res_chan), 32'd0);
      check({tag, "_ack"}, 32'(flush_ack), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_flush = '0;
      res_ready = 1'b1;
      step();
      step();
      outputs_zero("reset");
      rst = 1'b0;
      step();

      // Single channel: four 0x15 samples, result only after the fourth (4*0x15 mod 64 = 0x14).
      send(2'b01, 0, 6'h15); no_res();
      send(2'b01, 0, 6'h15); no_res();
      send(2'b01, 0, 6'h15); no_res();
      send(2'b01, 0, 6'h15); take_res(0, 6'h14);
      req_valid = '0;

      // Fresh reset, then both channels continuously valid: grants alternate from ch0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      send(2'b11, 0, 6'h01); no_res();
      send(2'b11, 1, 6'h10); no_res();
      send(2'b11, 0, 6'h02); no_res();
      send(2'b11, 1, 6'h11); no_res();
      send(2'b11, 0, 6'h03); no_res();
      send(2'b11, 1, 6'h12); no_res();
      send(2'b11, 0, 6'h04); take_res(0, 6'h0A);
      send(2'b11, 1, 6'h13); take_res(1, 6'h06);
      send(2'b11, 0, 6'h05); take_res(0, 6'h0E);
      send(2'b11, 1, 6'h14); take_res(1, 6'h0A);

      // Flush beats a simultaneous sample on ch1; ch1 then needs four new samples.
      req_valid = 2'b10;
      req_flush = 2'b10;
      #1;
      check("flush_beats_grant", 32'(req_ready), 32'd0);
      step();
      check("clear_strobe", 32'(filt_clear), 32'd1);
      check("clear_chan", 32'(filt_chan), 32'd1);
      check("clear_ack", 32'(flush_ack), 32'b10);
      check("clear_no_sample", 32'(filt_sample_valid), 32'd0);
      req_flush = '0;
      step();
      check("clear_done", 32'(filt_clear), 32'd0);
      check("ack_pulse", 32'(flush_ack), 32'd0);
      send(2'b10, 1, 6'h20); no_res();
      send(2'b10, 1, 6'h21); no_res();
      send(2'b10, 1, 6'h22); no_res();
      send(2'b10, 1, 6'h24); take_res(1, 6'h07);

      // Backpressure: result held stable for 10 cycles, no grants meanwhile.
      res_ready = 1'b0;
      send(2'b01, 0, 6'h06);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 32'(res_valid), 32'd1);
         check("bp_data", 32'(res_data), 32'h12);
         check("bp_chan", 32'(res_chan), 32'd0);
         check("bp_ready", 32'(req_ready), 32'd0);
         step();
      end
      res_ready = 1'b1;
      take_res(0, 6'h12);
      send(2'b01, 0, 6'h07); take_res(0, 6'h16);

      // Reset while in WAIT with a full window: everything drops at once.
      req_valid     = 2'b01;
      req_data[5:0] = 6'h08;
      step();
      step();
      rst = 1'b1;
      #1;
      outputs_zero("mid_reset");
      req_valid = '0;
      step();
      rst = 1'b0;
      step();
      no_res();
      send(2'b01, 0, 6'h01); no_res();
      send(2'b01, 0, 6'h01); no_res();
      send(2'b01, 0, 6'h01); no_res();
      send(2'b01, 0, 6'h01); take_res(0, 6'h04);

      // Flush raised during RESULT on the same channel: result first, then CLEAR.
      res_ready = 1'b0;
      send(2'b01, 0, 6'h02);
      req_valid = '0;
      req_flush = 2'b01;
      #1;
      check("pend_valid", 32'(res_valid), 32'd1);
      check("pend_ack", 32'(flush_ack), 32'd0);
      check("pend_clear", 32'(filt_clear), 32'd0);
      step();
      res_ready = 1'b1;
      take_res(0, 6'h05);
      check("idle_no_grant", 32'(req_ready), 32'd0);
      step();
      check("late_clear", 32'(filt_clear), 32'd1);
      check("late_chan", 32'(filt_chan), 32'd0);
      check("late_ack", 32'(flush_ack), 32'b01);
      req_flush = '0;
      step();
      check("late_ack_end", 32'(flush_ack), 32'd0);
      send(2'b01, 0, 6'h3F); no_res();
      req_valid = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ma_window_scheduler.md
Name: ma_window_scheduler

Overview:
- Shares one moving-average filter datapath (per-channel window context, 6-bit {t,y,x} samples) between NUM_REQ sample requesters.
- Round-robin arbitration over requester samples; sequences each accepted sample through the filter; tracks each channel's window fill.
- Emits a filter result only once that channel's window is full.
- Services per-channel flush requests by clearing that channel's filter context.

Parameters:
- NUM_REQ, 2, number of requesters/channels (2..4)
- WINDOW_SIZE, 4, samples per window before results are released
- DATA_W, 6, sample/result width ({t[1:0],y[1:0],x[1:0]})
- CH_W, 2, channel id width (>= clog2(NUM_REQ))

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  sample offered by requester i
- req_data  in  NUM_REQ*DATA_W  sample i at bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid & ready
- req_flush  in  NUM_REQ  level request to clear channel i window
- filt_sample_valid  out  1  one-cycle strobe: push filt_sample into channel filt_chan
- filt_sample  out  DATA_W  sample to filter
- filt_chan  out  CH_W  channel context selected in filter
- filt_clear  out  1  one-cycle strobe: clear filt_chan context
- filt_result  in  DATA_W  filter window sum for filt_chan, valid the cycle after filt_sample_valid
- res_valid  out  1  result available
- res_chan  out  CH_W  channel of result
- res_data  out  DATA_W  result value
- res_ready  in  1  consumer accepts result when res_valid & res_ready
- flush_ack  out  NUM_REQ  one-cycle pulse when flush i performed

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; fill counters 0; RR pointer = NUM_REQ-1 (channel 0 highest priority first). Reset mid-transaction aborts it: no strobe, pending result dropped.
- FSM states: IDLE, CLEAR, ISSUE, WAIT, RESULT.
- IDLE:
  - If any req_flush: go CLEAR with lowest-index flushing channel latched. Flush beats samples.
  - Else if any req_valid: pick first valid channel after RR pointer (wrapping); req_ready[g]=1 combinationally this cycle only; latch data/channel; pointer<=g; go ISSUE.
  - Else stay. req_ready is 0 in all other states.
- CLEAR (1 cycle): filt_clear=1, filt_chan=latched; fill[ch]<=0; flush_ack[ch]=1; go IDLE.
- ISSUE (1 cycle): filt_sample_valid=1 with latched sample/chan; fill[ch] increments, saturating at WINDOW_SIZE; go WAIT.
- WAIT (1 cycle): filt_chan held. If fill[ch]==WINDOW_SIZE, register filt_result into res_data and ch into res_chan, go RESULT. Else go IDLE with no result.
- RESULT: res_valid=1; res_data/res_chan stable until handshake; on res_ready go IDLE. Holds indefinitely under backpressure.
- Latency: sample accepted in cycle N; filt_sample_valid in N+1; result captured end of N+2; res_valid from N+3. Minimum 3 cycles per sample with no result (4 with result and res_ready=1).
- Fill counter width clog2(WINDOW_SIZE+1). The WINDOW_SIZE-th sample after reset/flush is the first to produce a result; every later sample also produces one.
- Simultaneous flush and valid on the same channel in IDLE: flush served first, sample granted on a later IDLE visit.
- Flush raised outside IDLE waits; a pending RESULT for that channel is still delivered.
- filt_chan is 0 in IDLE.
- Data is passed through unchanged. No arithmetic on samples.

Test Plan:
- Reset, then ch0 offers 6'h15 four times (ch1 idle) -> four filt_sample_valid strobes with chan 0. Results only after 4th accept; res_valid 3 cycles after that accept; res_data = filt_result model value, res_chan=0.
- ch0 and ch1 continuously valid -> grants alternate 0,1,0,1 starting with ch0. Each channel's first result follows its own 4th sample.
- After ch1 full, assert req_flush[1] with req_valid[1] -> CLEAR first (filt_clear=1, filt_chan=1, flush_ack[1] pulse), then sample granted. Next result for ch1 only after 4 further samples.
- Hold res_ready=0 for 10 cycles with result pending -> res_valid/res_data/res_chan stable, req_ready=0 throughout. Release -> IDLE next cycle, next grant follows.
- Assert rst in WAIT with fill==WINDOW_SIZE -> all outputs 0 immediately, no res_valid. After release the channel needs 4 new samples before a result.
- Flush raised during RESULT on the same channel -> result delivered first, then CLEAR cycle with flush_ack pulse.
